// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word RAM between an instruction cache and a data cache.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention; by default the data port wins.
module mem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 20,
    parameter int BURST_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_mem_valid_in,
    input  logic [ADDR_WIDTH-1:0] inst_mem_addr,
    output logic                  inst_mem_valid_out,
    output logic                  inst_mem_last,
    output logic [DATA_WIDTH-1:0] inst_mem_data,
    input  logic                  data_mem_valid_in,
    input  logic                  data_mem_rw,
    input  logic [ADDR_WIDTH-1:0] data_mem_addr,
    input  logic [DATA_WIDTH-1:0] data_mem_write,
    output logic                  data_mem_valid_out,
    output logic                  data_mem_last,
    output logic [DATA_WIDTH-1:0] data_mem_read,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        INST_BURST,
        DATA_BURST,
        DATA_WRITE,
        DRAIN
    } state_t;

    localparam logic [BURST_WIDTH-1:0] CNT_LAST    = '1;
    localparam logic [ADDR_WIDTH-1:0]  OFFSET_MASK = ADDR_WIDTH'((1 << BURST_WIDTH) - 1);

    state_t                  state;
    state_t                  state_next;
    logic [BURST_WIDTH-1:0]  cnt;
    logic [BURST_WIDTH-1:0]  cnt_next;
    logic [ADDR_WIDTH-1:0]   base;
    logic [ADDR_WIDTH-1:0]   base_next;
    logic                    rd_valid;
    logic                    rd_valid_next;
    logic                    rd_last;
    logic                    rd_last_next;
    logic                    rd_to_data;
    logic                    rd_to_data_next;
    logic                    grant_inst;
    logic                    grant_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                    favour_data;
`endif

    // Grants are only issued from IDLE; anything arriving mid-transfer simply waits.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state == IDLE) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (inst_mem_valid_in && (!data_mem_valid_in || !favour_data))
`else
            if (inst_mem_valid_in && !data_mem_valid_in)
`endif
                grant_inst = 1'b1;
            else if (data_mem_valid_in)
                grant_data = 1'b1;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        base_next       = base;
        rd_valid_next   = 1'b0;
        rd_last_next    = 1'b0;
        rd_to_data_next = rd_to_data;
        ram_en          = 1'b0;
        ram_we          = 1'b0;
        ram_addr        = base + ADDR_WIDTH'(cnt);
        ram_wdata       = data_mem_write;

        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (grant_inst) begin
                    state_next = INST_BURST;
                    base_next  = inst_mem_addr & ~OFFSET_MASK;
                end else if (grant_data) begin
                    if (data_mem_rw) begin
                        state_next = DATA_WRITE;
                    end else begin
                        state_next = DATA_BURST;
                        base_next  = data_mem_addr & ~OFFSET_MASK;
                    end
                end
            end
            // RAM returns each word a cycle later, so the port strobes are registered copies.
            INST_BURST, DATA_BURST: begin
                ram_en          = 1'b1;
                rd_valid_next   = 1'b1;
                rd_last_next    = (cnt == CNT_LAST);
                rd_to_data_next = (state == DATA_BURST);
                cnt_next        = cnt + BURST_WIDTH'(1);
                if (cnt == CNT_LAST)
                    state_next = DRAIN;
            end
            DATA_WRITE: begin
                ram_en     = 1'b1;
                ram_we     = 1'b1;
                ram_addr   = data_mem_addr;
                state_next = IDLE;
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            base       <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            rd_to_data <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            base       <= base_next;
            rd_valid   <= rd_valid_next;
            rd_last    <= rd_last_next;
            rd_to_data <= rd_to_data_next;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Pointer names the port that should win the next tie; starts on the instruction port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            favour_data <= 1'b0;
        else if (grant_inst)
            favour_data <= 1'b1;
        else if (grant_data)
            favour_data <= 1'b0;
    end
`endif

    assign inst_mem_valid_out = rd_valid && !rd_to_data;
    assign inst_mem_last      = rd_last && !rd_to_data;
    assign inst_mem_data      = ram_rdata;
    assign data_mem_valid_out = (rd_valid && rd_to_data) || (state == DATA_WRITE);
    assign data_mem_last      = (rd_last && rd_to_data) || (state == DATA_WRITE);
    assign data_mem_read      = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with a queue scoreboard for port words and RAM accesses.
// Expectations follow MEM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 20;
    localparam int BW = 3;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          inst_mem_valid_in = 1'b0;
    logic [AW-1:0] inst_mem_addr = '0;
    logic          inst_mem_valid_out;
    logic          inst_mem_last;
    logic [DW-1:0] inst_mem_data;
    logic          data_mem_valid_in = 1'b0;
    logic          data_mem_rw = 1'b0;
    logic [AW-1:0] data_mem_addr = '0;
    logic [DW-1:0] data_mem_write = '0;
    logic          data_mem_valid_out;
    logic          data_mem_last;
    logic [DW-1:0] data_mem_read;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_mem_valid_in(inst_mem_valid_in), .inst_mem_addr(inst_mem_addr),
        .inst_mem_valid_out(inst_mem_valid_out), .inst_mem_last(inst_mem_last),
        .inst_mem_data(inst_mem_data),
        .data_mem_valid_in(data_mem_valid_in), .data_mem_rw(data_mem_rw),
        .data_mem_addr(data_mem_addr), .data_mem_write(data_mem_write),
        .data_mem_valid_out(data_mem_valid_out), .data_mem_last(data_mem_last),
        .data_mem_read(data_mem_read),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    logic [DW-1:0] mem [0:4095];

    always @(posedge clk) begin
        if (ram_en && ram_we)
            mem[ram_addr[11:0]] <= ram_wdata;
        if (ram_en && !ram_we)
            ram_rdata <= mem[ram_addr[11:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [DW-1:0] val;
        logic          last;
        logic          chk_val;
    } word_t;

    typedef struct {
        int            at;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } ram_t;

    typedef logic [DW-1:0] blk_t [N];

    word_t q_inst[$];
    word_t q_data[$];
    ram_t  q_ram[$];
    int    vectors = 0;
    int    miscompares = 0;

    function automatic blk_t ramp(input logic [DW-1:0] first);
        blk_t b;
        for (int k = 0; k < N; k++)
            b[k] = first + DW'(k);
        return b;
    endfunction

    function automatic void push_burst(input logic to_data, input int start,
                                       input logic [AW-1:0] base, input blk_t vals);
        word_t w;
        for (int k = 0; k < N; k++) begin
            q_ram.push_back('{at: start + k, addr: base + AW'(k), we: 1'b0, wdata: '0});
            w = '{at: start + 1 + k, val: vals[k], last: (k == N - 1), chk_val: 1'b1};
            if (to_data)
                q_data.push_back(w);
            else
                q_inst.push_back(w);
        end
    endfunction

    function automatic void push_write(input int at, input logic [AW-1:0] addr,
                                       input logic [DW-1:0] wdata);
        q_ram.push_back('{at: at, addr: addr, we: 1'b1, wdata: wdata});
        q_data.push_back('{at: at, val: '0, last: 1'b1, chk_val: 1'b0});
    endfunction

    function automatic void check_output(input string name, input logic actual,
                                         input logic expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endfunction

    function automatic void check_word(input string name, input word_t e, input logic valid,
                                       input logic [DW-1:0] data, input logic last);
        if (valid !== 1'b1 || e.at != cyc || last !== e.last || (e.chk_val && data !== e.val)) begin
            miscompares++;
            $display("[TB] FAIL %s: got cyc=%0d valid=%b data=%h last=%b, expected cyc=%0d valid=1 data=%h last=%b",
                     name, cyc, valid, data, last, e.at, e.val, e.last);
        end
    endfunction

    // Monitor: every strobe the DUT presents must match the head of its queue, cycle included.
    word_t mon_w;
    ram_t  mon_r;
    always @(negedge clk) begin
        if (rst_n) begin
            if (inst_mem_valid_out || inst_mem_last) begin
                vectors++;
                if (q_inst.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL inst_word: got cyc=%0d data=%h last=%b, expected no word",
                             cyc, inst_mem_data, inst_mem_last);
                end else begin
                    mon_w = q_inst.pop_front();
                    check_word("inst_word", mon_w, inst_mem_valid_out, inst_mem_data, inst_mem_last);
                end
            end
            if (data_mem_valid_out || data_mem_last) begin
                vectors++;
                if (q_data.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL data_word: got cyc=%0d data=%h last=%b, expected no word",
                             cyc, data_mem_read, data_mem_last);
                end else begin
                    mon_w = q_data.pop_front();
                    check_word("data_word", mon_w, data_mem_valid_out, data_mem_read, data_mem_last);
                end
            end
            if (ram_en) begin
                vectors++;
                if (q_ram.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL ram_access: got cyc=%0d addr=%h we=%b, expected no access",
                             cyc, ram_addr, ram_we);
                end else begin
                    mon_r = q_ram.pop_front();
                    if (mon_r.at != cyc || ram_addr !== mon_r.addr || ram_we !== mon_r.we ||
                        (mon_r.we && ram_wdata !== mon_r.wdata)) begin
                        miscompares++;
                        $display("[TB] FAIL ram_access: got cyc=%0d addr=%h we=%b wdata=%h, expected cyc=%0d addr=%h we=%b wdata=%h",
                                 cyc, ram_addr, ram_we, ram_wdata, mon_r.at, mon_r.addr, mon_r.we, mon_r.wdata);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_output("rst_inst_valid", inst_mem_valid_out, 1'b0);
        check_output("rst_inst_last", inst_mem_last, 1'b0);
        check_output("rst_data_valid", data_mem_valid_out, 1'b0);
        check_output("rst_data_last", data_mem_last, 1'b0);
        check_output("rst_ram_en", ram_en, 1'b0);
        check_output("rst_ram_we", ram_we, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic req_inst(input logic [AW-1:0] addr);
        int n = 0;
        inst_mem_addr     = addr;
        inst_mem_valid_in = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_mem_last && n < 200);
        vectors++;
        if (!inst_mem_last) begin
            miscompares++;
            $display("[TB] FAIL inst_timeout: got no last in %0d cycles, expected last", n);
        end
        inst_mem_valid_in = 1'b0;
    endtask

    task automatic req_data(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int n = 0;
        data_mem_rw       = rw;
        data_mem_addr     = addr;
        data_mem_write    = wdata;
        data_mem_valid_in = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!data_mem_last && n < 200);
        vectors++;
        if (!data_mem_last) begin
            miscompares++;
            $display("[TB] FAIL data_timeout: got no last in %0d cycles, expected last", n);
        end
        data_mem_valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus();
        int   c;
        blk_t rb;

        for (int i = 0; i < 4096; i++)
            mem[i] = '0;
        for (int k = 0; k < N; k++) begin
            mem[12'h010 + k] = 32'hA0 + k;
            mem[12'h040 + k] = 32'hB0 + k;
            mem[12'h080 + k] = 32'hC0 + k;
            mem[12'h0C0 + k] = 32'hD0 + k;
        end

        #2;
        apply_reset();

        // Single instruction block read from an unaligned address.
        @(negedge clk);
        c = cyc;
        push_burst(1'b0, c + 1, 20'h00010, ramp(32'hA0));
        req_inst(20'h00013);

        // Single-word write, then a read issued the first cycle the arbiter is idle again.
        @(negedge clk);
        c = cyc;
        push_write(c + 1, 20'h00400, 32'hDEADBEEF);
        req_data(1'b1, 20'h00400, 32'hDEADBEEF);
        @(negedge clk);
        c = cyc;
        push_burst(1'b0, c + 1, 20'h000C0, ramp(32'hD0));
        req_inst(20'h000C7);

        // Simultaneous requests straight after reset.
        @(negedge clk);
        apply_reset();
        @(negedge clk);
        c = cyc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push_burst(1'b0, c + 1, 20'h00010, ramp(32'hA0));
        push_burst(1'b1, c + 11, 20'h00040, ramp(32'hB0));
`else
        push_burst(1'b1, c + 1, 20'h00040, ramp(32'hB0));
        push_burst(1'b0, c + 11, 20'h00010, ramp(32'hA0));
`endif
        fork
            req_inst(20'h00014);
            req_data(1'b0, 20'h00041, '0);
        join

        // Both ports keep re-requesting: two reads each.
        @(negedge clk);
        c = cyc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push_burst(1'b0, c + 1, 20'h00010, ramp(32'hA0));
        push_burst(1'b1, c + 11, 20'h00040, ramp(32'hB0));
        push_burst(1'b0, c + 21, 20'h00080, ramp(32'hC0));
        push_burst(1'b1, c + 31, 20'h000C0, ramp(32'hD0));
`else
        push_burst(1'b1, c + 1, 20'h00040, ramp(32'hB0));
        push_burst(1'b1, c + 11, 20'h000C0, ramp(32'hD0));
        push_burst(1'b0, c + 21, 20'h00010, ramp(32'hA0));
        push_burst(1'b0, c + 31, 20'h00080, ramp(32'hC0));
`endif
        fork
            begin
                req_inst(20'h00012);
                @(negedge clk);
                req_inst(20'h00087);
            end
            begin
                req_data(1'b0, 20'h00040, '0);
                @(negedge clk);
                req_data(1'b0, 20'h000C3, '0);
            end
        join

        // Reset in the fourth cycle of an instruction burst abandons it.
        @(negedge clk);
        c = cyc;
        for (int k = 0; k < 3; k++)
            q_ram.push_back('{at: c + 1 + k, addr: 20'h00010 + AW'(k), we: 1'b0, wdata: '0});
        q_inst.push_back('{at: c + 2, val: 32'hA0, last: 1'b0, chk_val: 1'b1});
        q_inst.push_back('{at: c + 3, val: 32'hA1, last: 1'b0, chk_val: 1'b1});
        inst_mem_addr     = 20'h00015;
        inst_mem_valid_in = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        inst_mem_valid_in = 1'b0;
        apply_reset();
        @(negedge clk);
        c = cyc;
        push_burst(1'b0, c + 1, 20'h00080, ramp(32'hC0));
        req_inst(20'h00080);

        // Data write arriving mid-burst waits for the arbiter to go idle.
        @(negedge clk);
        c = cyc;
        push_burst(1'b0, c + 1, 20'h00010, ramp(32'hA0));
        push_write(c + 11, 20'h00405, 32'h12345678);
        fork
            req_inst(20'h00010);
            begin
                repeat (3) @(negedge clk);
                req_data(1'b1, 20'h00405, 32'h12345678);
            end
        join

        // Read back the block holding both written words.
        @(negedge clk);
        c = cyc;
        rb = '{default: '0};
        rb[0] = 32'hDEADBEEF;
        rb[5] = 32'h12345678;
        push_burst(1'b1, c + 1, 20'h00400, rb);
        req_data(1'b0, 20'h00402, '0);

        repeat (4) @(negedge clk);
    endtask

    task automatic check_output_pending();
        vectors++;
        if (q_inst.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL inst_pending: got %0d words outstanding, expected 0", q_inst.size());
        end
        vectors++;
        if (q_data.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL data_pending: got %0d words outstanding, expected 0", q_data.size());
        end
        vectors++;
        if (q_ram.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL ram_pending: got %0d accesses outstanding, expected 0", q_ram.size());
        end
    endtask

    initial begin
        apply_stimulus();
        check_output_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 32, word width.
REQ-002 Parameter: ADDR_WIDTH, 20, main-memory word-address width.
REQ-003 Parameter: BURST_WIDTH, 3, log2 of words per cache block (burst length N = 2^BURST_WIDTH = 8).
REQ-004 Port: clk  in  1  single clock; all state changes on posedge clk.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: inst_mem_valid_in  in  1  instruction-cache block-read request, held until inst_mem_last.
REQ-007 Port: inst_mem_addr  in  ADDR_WIDTH  instruction request address; low BURST_WIDTH bits ignored.
REQ-008 Port: inst_mem_valid_out / inst_mem_last / inst_mem_data  out  1/1/DATA_WIDTH  returned word strobe, final-word flag, word.
REQ-009 Port: data_mem_valid_in, data_mem_rw  in  1,1  data-cache request; rw 0 = block read, 1 = single-word write.
REQ-010 Port: data_mem_addr / data_mem_write  in  ADDR_WIDTH/DATA_WIDTH  data request address, write word.
REQ-011 Port: data_mem_valid_out / data_mem_last / data_mem_read  out  1/1/DATA_WIDTH  as REQ-008 for data port.
REQ-012 Port: ram_en, ram_we  out  1,1  RAM access strobe, write enable.
REQ-013 Port: ram_addr / ram_wdata  out  ADDR_WIDTH/DATA_WIDTH  RAM word address, write data.
REQ-014 Port: ram_rdata  in  DATA_WIDTH  RAM read data, valid exactly one cycle after ram_en with ram_we=0.

Function
REQ-015 States SHALL be IDLE, INST_BURST, DATA_BURST, DATA_WRITE, DRAIN.
REQ-016 In IDLE, request sampled at edge T SHALL move state to its grant state at T+1; no request -> stay IDLE.
REQ-017 Burst: base = addr with low BURST_WIDTH bits zeroed, latched at grant; counter cnt cleared.
REQ-018 Burst states: ram_en=1, ram_we=0, ram_addr=base+cnt for cycles T+1..T+N; cnt increments each cycle, wrapping 0..N-1; after cnt=N-1 -> DRAIN.
REQ-019 Returned words: granted port's valid_out=1 with data=ram_rdata in cycles T+2..T+N+1, in ascending offset order; last=1 only at T+N+1.
REQ-020 DRAIN lasts one cycle (the T+N+1 last-word cycle), then IDLE at T+N+2.
REQ-021 DATA_WRITE (one cycle, T+1): ram_en=ram_we=1, ram_addr=data_mem_addr, ram_wdata=data_mem_write; data_mem_valid_out=data_mem_last=1; then IDLE.
REQ-022 Ungranted port's valid_out and last SHALL stay 0; its request is held off, not dropped.
REQ-023 Requests arriving outside IDLE SHALL be ignored until IDLE; a request still high in IDLE is a new request.
REQ-024 Outside active cycles ram_en=ram_we=0; data/addr outputs are don't-care.
REQ-025 Lone requester is always granted regardless of arbitration policy.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, cnt=0, all valid_out/last/ram_en/ram_we=0, mid-burst included; partial burst is abandoned, no last issued.
REQ-027 After reset the arbitration pointer SHALL favour the instruction port.

Configuration
REQ-028 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests grant the port not granted most recently (pointer updated at each grant).
REQ-029 Macro undefined: on simultaneous requests the data port always wins; no pointer register.

Verification
REQ-030 Inst read addr 0x00013, RAM[0x10+k]=k+0xA0 -> ram_addr 0x10..0x17 at T+1..T+8; inst words 0xA0..0xA7 at T+2..T+9, last only at T+9.
REQ-031 Data write addr 0x00400, data 0xDEADBEEF -> T+1: ram_we=1, ram_addr 0x00400, data_mem_valid_out=data_mem_last=1; IDLE at T+2.
REQ-032 Both request at T after reset, round-robin on -> inst burst first, data burst starts T+11; macro off -> data first.
REQ-033 Round-robin, both requesters continuously re-requesting -> grants alternate inst, data, inst, data.
REQ-034 rst_n asserted at T+4 of inst burst -> outputs 0 same cycle, no last; fresh request after release completes normally.
REQ-035 Data request arriving at T+3 of inst burst -> no data output until IDLE, then granted next cycle.
